mdu_iter: RTL and testbench
===========================

Name: mdu_iter

Overview:
- Iterative RV64M multiply/divide unit: the responder for the execute stage's multi-cycle ALU request handshake (en / ready / valid).
- Execute drives operands plus an `en` request, and holds them until `ready`. The unit computes over several cycles, then presents the result for exactly one cycle with `valid` and `ready` both high, so execute can advance its pipeline register.
- Sits beside the single-cycle ALU inside the execute stage.

Parameters:
- XLEN, 64, datapath width; W-variants operate on the low 32 bits.

Ports:
- clk    input  1     clock, all state on rising edge
- rst    input  1     synchronous reset, active-high
- en     input  1     request valid; in0/in1/func3/op_w stable while en && !ready
- in0    input  XLEN  rs1 operand (multiplicand / dividend)
- in1    input  XLEN  rs2 operand (multiplier / divisor)
- func3  input  3     RV M func3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- op_w   input  1     1 = W variant (MULW/DIVW/DIVUW/REMW/REMUW); op_w with func3 001–011 is illegal and is treated as MULW
- ready  output 1     combinational: (state==IDLE && !en) || state==DONE
- valid  output 1     registered: state==DONE
- out    output XLEN  result, meaningful only when valid; held 0 otherwise

Behaviour:
- Reset (rst=1 at edge):
  - state=IDLE, out=0, valid=0, internal counters/accumulators cleared.
  - Overrides any operation in progress; the partial result is discarded and no valid pulse is issued.
- States: IDLE, BUSY, DONE.
- IDLE, en=0: stay; ready=1.
- IDLE, en=1: ready=0. Latch the operands, precomputing signs and absolute values for signed ops. W ops truncate to 32 bits, then sign- or zero-extend per op. Load the counter with N = 64 (op_w=0) or 32 (op_w=1). Go to BUSY.
- Special cases detected in IDLE, which go straight to DONE with no BUSY cycles:
  - Divide by zero: DIV/DIVU quotient = all ones; REM/REMU = dividend.
  - Signed overflow (dividend = most-negative, divisor = -1): DIV = dividend, REM = 0.
  - W variants apply the same rules on 32-bit values.
- BUSY, multiply: one shift-add step per cycle over the 2N-bit product.
- BUSY, divide: one restoring step per cycle (shift remainder, trial subtract, set quotient bit).
- BUSY exit: when the counter reaches 0, apply the sign fix-up:
  - quotient negated if the operand signs differ;
  - remainder takes the dividend's sign.
  - Register `out`, go to DONE.
- Latency, en accepted to valid:
  - N+1 cycles in BUSY: 65 for 64-bit ops, 33 for W ops.
  - 1 cycle for special cases.
- Result selection:
  - MUL/MULW: low half.
  - MULH/MULHSU/MULHU: high 64 bits.
  - DIV*: quotient.
  - REM*: remainder.
  - All W results sign-extended from bit 31.
- DONE: valid=1, ready=1 for exactly one cycle, then IDLE unconditionally. en during DONE belongs to the retiring request and is ignored. A new request is sampled in IDLE on the following cycle, so back-to-back operations incur one idle cycle.
- en deasserted during BUSY (producer misbehaviour): the operation completes and the valid pulse is still issued.
- out returns to 0 on leaving DONE.

Optional Feature:
- Macro: MDU_ZERO_SKIP_EN.
- Defined: a multiply with either masked operand equal to 0 goes IDLE→DONE directly with out=0 (1-cycle latency).
- Undefined: zero operands take the full N+1 cycles and still yield 0.
- Divide timing is identical either way.

Decomposition:
- Package mdu_pkg:
  - func3 constants (F3_MUL … F3_REMU);
  - state enum {IDLE, BUSY, DONE};
  - XLEN default.
- One sub-module, mdu_div_step: a combinational single restoring-division step.
  - Inputs: partial remainder, dividend bit, divisor.
  - Outputs: next remainder, quotient bit.
- Shift-add multiply stays inline.

Test Plan:
- MUL in0=7, in1=-3 → valid after 65 cycles, out=0xFFFF_FFFF_FFFF_FFEB; ready low throughout BUSY.
- MULHU in0=in1=0xFFFF_FFFF_FFFF_FFFF → out=0xFFFF_FFFF_FFFF_FFFE. MULH with the same operands → out=0.
- DIV in0=-7, in1=2 → out=-3 (0xFFFF_FFFF_FFFF_FFFD). REM with the same operands → out=-1. DIVW in0=0x1_0000_0010, in1=4 → out=4 after 33 cycles.
- DIVU in1=0 → valid one cycle after accept, out=all ones. REM in0=0x8000_0000_0000_0000, in1=-1 → out=0, 1-cycle latency.
- Assert rst on cycle 20 of a DIV → next cycle: state IDLE, ready=1, valid never pulses. A new request afterwards completes correctly.
- MUL in0=0, in1=5 → valid after 1 cycle with MDU_ZERO_SKIP_EN defined, after 65 cycles without it; out=0 in both builds. Back-to-back requests: valid pulses are exactly one cycle wide, separated by the one mandatory IDLE cycle.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit: RV M func3 codes, FSM states, default width.
package mdu_pkg;

  localparam int XLEN_DEFAULT = 64;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mdu_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract the divisor.
// Purely combinational, no flow control.
module mdu_div_step
  import mdu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [XLEN-1:0] i_rem,
  input  logic            i_dbit,
  input  logic [XLEN-1:0] i_dvsr,
  output logic [XLEN-1:0] o_rem,
  output logic            o_qbit
);

  logic [XLEN:0] w_shift;

  assign w_shift = {i_rem, i_dbit};
  assign o_qbit  = (w_shift >= {1'b0, i_dvsr});
  // The difference is below the divisor whenever it is kept, so it always fits XLEN bits.
  assign o_rem   = o_qbit ? XLEN'(w_shift - {1'b0, i_dvsr}) : w_shift[XLEN-1:0];

endmodule

// File: rtl/mdu_iter.sv
// Iterative RV64M mul/div: N+1 BUSY cycles (N=64, 32 for W ops), 1 cycle for div-by-zero/overflow.
// ready low while busy, one-cycle valid+ready pulse in DONE; MDU_ZERO_SKIP_EN short-circuits zero multiplies.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [XLEN-1:0] in0,
  input  logic [XLEN-1:0] in1,
  input  logic [2:0]      func3,
  input  logic            op_w,
  output logic            ready,
  output logic            valid,
  output logic [XLEN-1:0] out
);

  localparam int CW = $clog2(XLEN + 1);

  function automatic logic [XLEN-1:0] sext_w(input logic [31:0] v);
    return {{(XLEN-32){v[31]}}, v};
  endfunction

  function automatic logic [XLEN-1:0] zext_w(input logic [31:0] v);
    return {{(XLEN-32){1'b0}}, v};
  endfunction

  state_t            r_state, w_state_nxt;
  logic [CW-1:0]     r_cnt;
  logic              r_is_div, r_op_w, r_sel_rem, r_mul_hi, r_neg_q, r_neg_r;
  logic [2*XLEN-1:0] r_acc, r_mcand;
  logic [XLEN-1:0]   r_mplier, r_rem, r_quo, r_dvsr;

  // Request decode, valid only while sampling en in IDLE.
  logic            w_is_div, w_sgn_a, w_sgn_b, w_neg_a, w_neg_b;
  logic            w_div0, w_ovf, w_zero_mul, w_special;
  logic [XLEN-1:0] w_a, w_b, w_abs_a, w_abs_b, w_min, w_special_res;

  assign w_is_div = func3[2];
  assign w_sgn_a  = w_is_div ? !func3[0] : (op_w || func3 != F3_MULHU);
  assign w_sgn_b  = w_is_div ? !func3[0] : (op_w || func3 == F3_MUL || func3 == F3_MULH);
  assign w_a      = !op_w ? in0 : (w_sgn_a ? sext_w(in0[31:0]) : zext_w(in0[31:0]));
  assign w_b      = !op_w ? in1 : (w_sgn_b ? sext_w(in1[31:0]) : zext_w(in1[31:0]));
  assign w_neg_a  = w_sgn_a && w_a[XLEN-1];
  assign w_neg_b  = w_sgn_b && w_b[XLEN-1];
  assign w_abs_a  = w_neg_a ? -w_a : w_a;
  assign w_abs_b  = w_neg_b ? -w_b : w_b;
  assign w_min    = op_w ? sext_w(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
  assign w_div0   = w_is_div && (w_b == '0);
  assign w_ovf    = w_is_div && !func3[0] && (w_a == w_min) && (w_b == '1);

`ifdef MDU_ZERO_SKIP_EN
  assign w_zero_mul = !w_is_div && (w_a == '0 || w_b == '0);
`else
  assign w_zero_mul = 1'b0;
`endif

  assign w_special = w_div0 || w_ovf || w_zero_mul;

  always_comb begin
    w_special_res = '0;
    if (w_div0)
      w_special_res = func3[1] ? (op_w ? sext_w(in0[31:0]) : in0) : '1;
    else if (w_ovf && !func3[1])
      w_special_res = w_a;
  end

  // Shared datapath steps and the sign fix-up applied on BUSY exit.
  logic [XLEN-1:0]   w_rem_nxt, w_quo_fix, w_rem_fix, w_res_raw, w_res;
  logic              w_qbit;
  logic [2*XLEN-1:0] w_prod_fix;

  mdu_div_step #(.XLEN(XLEN)) u_div_step (
    .i_rem  (r_rem),
    .i_dbit (r_quo[XLEN-1]),
    .i_dvsr (r_dvsr),
    .o_rem  (w_rem_nxt),
    .o_qbit (w_qbit)
  );

  assign w_prod_fix = r_neg_q ? -r_acc : r_acc;
  assign w_quo_fix  = r_neg_q ? -r_quo : r_quo;
  assign w_rem_fix  = r_neg_r ? -r_rem : r_rem;
  assign w_res_raw  = r_is_div ? (r_sel_rem ? w_rem_fix : w_quo_fix)
                               : (r_mul_hi ? w_prod_fix[2*XLEN-1:XLEN] : w_prod_fix[XLEN-1:0]);
  assign w_res      = r_op_w ? sext_w(w_res_raw[31:0]) : w_res_raw;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (en) w_state_nxt = w_special ? DONE : BUSY;
      BUSY:    if (r_cnt == '0) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign ready = (r_state == IDLE && !en) || (r_state == DONE);
  assign valid = (r_state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_is_div  <= 1'b0;
      r_op_w    <= 1'b0;
      r_sel_rem <= 1'b0;
      r_mul_hi  <= 1'b0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_dvsr    <= '0;
      out       <= '0;
    end else begin
      case (r_state)
        IDLE: if (en) begin
          r_cnt     <= op_w ? CW'(32) : CW'(XLEN);
          r_is_div  <= w_is_div;
          r_op_w    <= op_w;
          r_sel_rem <= func3[1];
          r_mul_hi  <= !op_w && (func3[1:0] != 2'b00);
          r_neg_q   <= w_neg_a ^ w_neg_b;
          r_neg_r   <= w_neg_a;
          r_acc     <= '0;
          r_mcand   <= {{XLEN{1'b0}}, w_abs_a};
          r_mplier  <= w_abs_b;
          r_rem     <= '0;
          // W dividends are left-aligned so the step always consumes bit XLEN-1.
          r_quo     <= op_w ? {w_abs_a[31:0], {(XLEN-32){1'b0}}} : w_abs_a;
          r_dvsr    <= w_abs_b;
          if (w_special) out <= w_special_res;
        end
        BUSY: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
            if (r_is_div) begin
              r_rem <= w_rem_nxt;
              r_quo <= {r_quo[XLEN-2:0], w_qbit};
            end else begin
              if (r_mplier[0]) r_acc <= r_acc + r_mcand;
              r_mcand  <= r_mcand << 1;
              r_mplier <= r_mplier >> 1;
            end
          end else begin
            out <= w_res;
          end
        end
        DONE:    out <= '0;
        default: out <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter: per-feature tasks with hand-computed results, latency and handshake checks.
module tb_mdu_iter;

  localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
  localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

  logic        clk = 1'b0;
  logic        rst, en, op_w, ready, valid;
  logic [63:0] in0, in1, out;
  logic [2:0]  func3;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  mdu_iter #(.XLEN(64)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .in0   (in0),
    .in1   (in1),
    .func3 (func3),
    .op_w  (op_w),
    .ready (ready),
    .valid (valid),
    .out   (out)
  );

  // Issues one request and reports the result, the number of non-valid cycles after the
  // accept edge (BUSY cycles), ready-high samples while busy, and the cycle after DONE.
  task automatic run_op(input logic [2:0] f3, input logic w, input logic [63:0] a, input logic [63:0] b,
                        output logic [63:0] res, output int busy, output int rdy_bad,
                        output logic nxt_vld, output logic [63:0] nxt_out);
    bit done;
    done = 1'b0; busy = 0; rdy_bad = 0; res = '0; nxt_vld = 1'b0; nxt_out = '0;
    @(negedge clk);
    func3 = f3; op_w = w; in0 = a; in1 = b; en = 1'b1;
    for (int i = 0; i < 300 && !done; i++) begin
      @(posedge clk); #1;
      if (valid) begin
        res = out; done = 1'b1;
      end else begin
        busy++;
        if (ready) rdy_bad++;
      end
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL timeout: no valid within 300 cycles f3=%0d w=%0d", f3, w);
    end
    @(negedge clk); en = 1'b0;
    @(posedge clk); #1;
    nxt_vld = valid; nxt_out = out;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; in0 = '0; in1 = '0; func3 = MUL; op_w = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b want 1", ready); end
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", valid); end
    checks++; if (out !== 64'h0) begin failures++; $display("FAIL reset_out: got %h want 0", out); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_mul();
    logic [63:0] r, no; int b, rb; logic nv;
    run_op(MUL, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, r, b, rb, nv, no);
    checks++; if (r !== 64'hFFFF_FFFF_FFFF_FFEB) begin failures++; $display("FAIL mul_out: got %h want ffffffffffffffeb", r); end
    checks++; if (b !== 65) begin failures++; $display("FAIL mul_busy_cycles: got %0d want 65", b); end
    checks++; if (rb !== 0) begin failures++; $display("FAIL mul_ready_in_busy: got %0d want 0", rb); end
    checks++; if (nv !== 1'b0) begin failures++; $display("FAIL mul_valid_width: got %b want 0", nv); end
    checks++; if (no !== 64'h0) begin failures++; $display("FAIL mul_out_after_done: got %h want 0", no); end
  endtask

  task automatic test_mulh();
    logic [63:0] r, no; int b, rb; logic nv;
    run_op(MULHU, 1'b0, '1, '1, r, b, rb, nv, no);
    checks++; if (r !== 64'hFFFF_FFFF_FFFF_FFFE) begin failures++; $display("FAIL mulhu_out: got %h want fffffffffffffffe", r); end
    run_op(MULH, 1'b0, '1, '1, r, b, rb, nv, no);
    checks++; if (r !== 64'h0) begin failures++; $display("FAIL mulh_out: got %h want 0", r); end
    run_op(MULHSU, 1'b0, '1, 64'd2, r, b, rb, nv, no);
    checks++; if (r !== 64'hFFFF_FFFF_FFFF_FFFF) begin failures++; $display("FAIL mulhsu_out: got %h want ffffffffffffffff", r); end
    run_op(MUL, 1'b1, 64'h7FFF_FFFF, 64'd2, r, b, rb, nv, no);
    checks++; if (r !== 64'hFFFF_FFFF_FFFF_FFFE) begin failures++; $display("FAIL mulw_out: got %h want fffffffffffffffe", r); end
    checks++; if (b !== 33) begin failures++; $display("FAIL mulw_busy_cycles: got %0d want 33", b); end
  endtask

  task automatic test_div();
    logic [63:0] r, no; int b, rb; logic nv;
    run_op(DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, r, b, rb, nv, no);
    checks++; if (r !== 64'hFFFF_FFFF_FFFF_FFFD) begin failures++; $display("FAIL div_out: got %h want fffffffffffffffd", r); end
    checks++; if (b !== 65) begin failures++; $display("FAIL div_busy_cycles: got %0d want 65", b); end
    run_op(REM, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, r, b, rb, nv, no);
    checks++; if (r !== 64'hFFFF_FFFF_FFFF_FFFF) begin failures++; $display("FAIL rem_out: got %h want ffffffffffffffff", r); end
    run_op(DIV, 1'b1, 64'h1_0000_0010, 64'd4, r, b, rb, nv, no);
    checks++; if (r !== 64'd4) begin failures++; $display("FAIL divw_out: got %h want 4", r); end
    checks++; if (b !== 33) begin failures++; $display("FAIL divw_busy_cycles: got %0d want 33", b); end
    run_op(DIVU, 1'b0, 64'd100, 64'd7, r, b, rb, nv, no);
    checks++; if (r !== 64'd14) begin failures++; $display("FAIL divu_out: got %h want e", r); end
    run_op(REMU, 1'b0, 64'd100, 64'd7, r, b, rb, nv, no);
    checks++; if (r !== 64'd2) begin failures++; $display("FAIL remu_out: got %h want 2", r); end
    run_op(REM, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, r, b, rb, nv, no);
    checks++; if (r !== 64'hFFFF_FFFF_FFFF_FFFF) begin failures++; $display("FAIL remw_out: got %h want ffffffffffffffff", r); end
  endtask

  task automatic test_special();
    logic [63:0] r, no; int b, rb; logic nv;
    run_op(DIVU, 1'b0, 64'd1234, 64'd0, r, b, rb, nv, no);
    checks++; if (r !== 64'hFFFF_FFFF_FFFF_FFFF) begin failures++; $display("FAIL divu_by0_out: got %h want ffffffffffffffff", r); end
    checks++; if (b !== 0) begin failures++; $display("FAIL divu_by0_busy: got %0d want 0", b); end
    checks++; if (nv !== 1'b0) begin failures++; $display("FAIL divu_by0_valid_width: got %b want 0", nv); end
    run_op(REM, 1'b0, 64'h8000_0000_0000_0000, '1, r, b, rb, nv, no);
    checks++; if (r !== 64'h0) begin failures++; $display("FAIL rem_ovf_out: got %h want 0", r); end
    checks++; if (b !== 0) begin failures++; $display("FAIL rem_ovf_busy: got %0d want 0", b); end
    run_op(DIV, 1'b0, 64'h8000_0000_0000_0000, '1, r, b, rb, nv, no);
    checks++; if (r !== 64'h8000_0000_0000_0000) begin failures++; $display("FAIL div_ovf_out: got %h want 8000000000000000", r); end
    run_op(REM, 1'b0, 64'h1234, 64'd0, r, b, rb, nv, no);
    checks++; if (r !== 64'h1234) begin failures++; $display("FAIL rem_by0_out: got %h want 1234", r); end
    run_op(DIV, 1'b1, 64'h8000_0000, 64'h0000_0000_FFFF_FFFF, r, b, rb, nv, no);
    checks++; if (r !== 64'hFFFF_FFFF_8000_0000) begin failures++; $display("FAIL divw_ovf_out: got %h want ffffffff80000000", r); end
    checks++; if (b !== 0) begin failures++; $display("FAIL divw_ovf_busy: got %0d want 0", b); end
  endtask

  task automatic test_rst_mid();
    logic [63:0] r, no; int b, rb; logic nv; int vcnt;
    @(negedge clk);
    func3 = DIV; op_w = 1'b0; in0 = 64'hFFFF_FFFF_FFFF_FF9C; in1 = 64'd7; en = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk); rst = 1'b1; en = 1'b0;
    @(posedge clk); #1;
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL rst_mid_ready: got %b want 1", ready); end
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL rst_mid_valid: got %b want 0", valid); end
    @(negedge clk); rst = 1'b0;
    vcnt = 0;
    repeat (80) begin
      @(posedge clk); #1;
      if (valid) vcnt++;
    end
    checks++; if (vcnt !== 0) begin failures++; $display("FAIL rst_mid_no_pulse: got %0d pulses want 0", vcnt); end
    run_op(DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, r, b, rb, nv, no);
    checks++; if (r !== 64'hFFFF_FFFF_FFFF_FFF2) begin failures++; $display("FAIL rst_mid_after_out: got %h want fffffffffffffff2", r); end
    checks++; if (b !== 65) begin failures++; $display("FAIL rst_mid_after_busy: got %0d want 65", b); end
  endtask

  task automatic test_zero_mul();
    logic [63:0] r, no; int b, rb; logic nv; int exp_busy;
`ifdef MDU_ZERO_SKIP_EN
    exp_busy = 0;
`else
    exp_busy = 65;
`endif
    run_op(MUL, 1'b0, 64'd0, 64'd5, r, b, rb, nv, no);
    checks++; if (r !== 64'h0) begin failures++; $display("FAIL zero_mul_out: got %h want 0", r); end
    checks++; if (b !== exp_busy) begin failures++; $display("FAIL zero_mul_busy: got %0d want %0d", b, exp_busy); end
  endtask

  task automatic test_back_to_back();
    logic v0, v1, v2, v3, r1;
    logic [63:0] o0, o1, o2;
    logic [63:0] r, no; int b, rb; logic nv;
    @(negedge clk);
    func3 = DIVU; op_w = 1'b0; in0 = 64'h99; in1 = 64'd0; en = 1'b1;
    @(posedge clk); #1; v0 = valid; o0 = out;
    @(negedge clk); func3 = REMU; in0 = 64'h55;
    @(posedge clk); #1; v1 = valid; o1 = out; r1 = ready;
    @(posedge clk); #1; v2 = valid; o2 = out;
    @(negedge clk); en = 1'b0;
    @(posedge clk); #1; v3 = valid;
    checks++; if (v0 !== 1'b1 || o0 !== 64'hFFFF_FFFF_FFFF_FFFF) begin failures++; $display("FAIL b2b_first: got valid=%b out=%h want 1 ffffffffffffffff", v0, o0); end
    checks++; if (v1 !== 1'b0 || o1 !== 64'h0 || r1 !== 1'b0) begin failures++; $display("FAIL b2b_idle_gap: got valid=%b out=%h ready=%b want 0 0 0", v1, o1, r1); end
    checks++; if (v2 !== 1'b1 || o2 !== 64'h55) begin failures++; $display("FAIL b2b_second: got valid=%b out=%h want 1 55", v2, o2); end
    checks++; if (v3 !== 1'b0) begin failures++; $display("FAIL b2b_second_width: got %b want 0", v3); end
    run_op(MUL, 1'b0, 64'd6, 64'd9, r, b, rb, nv, no);
    checks++; if (r !== 64'd54) begin failures++; $display("FAIL b2b_mul_out: got %h want 36", r); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mulh();
    test_div();
    test_special();
    test_rst_mid();
    test_zero_mul();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
